// File: rtl/ram_stream_loader.sv
// ram_stream_loader
//   Loads a valid/ready word stream into a 2**ADDR_WIDTH x DATA_WIDTH register
//   array, starting at a programmable address, and offers a whole-array
//   zero-fill. The read port is combinational (addr -> q), so the loaded table
//   can stand in for one of the fixed-content asynchronous ROMs.
//
// Ports
//   clk, rst_n   rising-edge clock, asynchronous active-low reset
//   start        begin a load (sampled in IDLE only); captures start_addr, len
//   start_addr   first write address
//   len          words to write, 0..DEPTH (0 -> done pulse, no writes)
//   clear        zero-fill the array (sampled in IDLE only, wins over start)
//   wr_valid     stream word present
//   wr_data      stream word
//   wr_ready     high for the whole of LOAD
//   busy         registered, high in LOAD or CLEAR
//   done         registered one-cycle pulse after a load / clear completes
//   addr, q      asynchronous read port, q = mem[addr]

// One storage word. Reset clears it; a decoded write enable loads it.
module ram_stream_loader_word #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= wdata;
    end
endmodule

module ram_stream_loader #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   len,
    input  logic                  clear,
    input  logic                  wr_valid,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_ready,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_WIDTH-1:0] addr,
    output logic [DATA_WIDTH-1:0] q
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic [1:0] {IDLE, LOAD, CLEAR} state_t;

    // Single write request shared by the stream path and the zero-fill path.
    typedef struct packed {
        logic                  en;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wr_req_t;

    state_t                            state;
    logic [ADDR_WIDTH-1:0]             ptr;
    logic [ADDR_WIDTH:0]               remaining;
    wr_req_t                           wreq;
    logic [DEPTH-1:0]                  word_we;
    logic [DEPTH-1:0][DATA_WIDTH-1:0]  mem;

    assign wr_ready = (state == LOAD);

    always_comb begin
        wreq      = '0;
        wreq.addr = ptr;
        unique case (state)
            LOAD: begin
                wreq.en   = wr_valid;
                wreq.data = wr_data;
            end
            CLEAR: begin
                wreq.en   = 1'b1;
                wreq.data = '0;
            end
            default: wreq.en = 1'b0;
        endcase
    end

    // Storage: one word cell per location, enable decoded from the request.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign word_we[i] = wreq.en && (wreq.addr == ADDR_WIDTH'(i));

        ram_stream_loader_word #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_word (
            .clk   (clk),
            .rst_n (rst_n),
            .we    (word_we[i]),
            .wdata (wreq.data),
            .q     (mem[i])
        );
    end

    assign q = mem[addr];

    // Control FSM. busy tracks the next state so it is registered alongside it;
    // done is a default-low pulse raised only on a completing edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (clear) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end else if (start) begin
                        if (len != '0) begin
                            state     <= LOAD;
                            ptr       <= start_addr;
                            remaining <= len;
                            busy      <= 1'b1;
                        end else begin
                            // Empty load: nothing to write, just acknowledge.
                            done <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (wr_valid) begin
                        // ptr wraps naturally at DEPTH, so a full-length load
                        // from any start address touches every word once.
                        ptr       <= ptr + ADDR_WIDTH'(1);
                        remaining <= remaining - (ADDR_WIDTH+1)'(1);
                        if (remaining == (ADDR_WIDTH+1)'(1)) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    ptr <= ptr + ADDR_WIDTH'(1);
                    if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end
endmodule
